// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs multi-cycle mult/div, single-cycle mthi/mtlo.
// Define MDU_MADD_EN to add madd/maddu/msub/msubu (accumulate into {HI,LO}).
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        flush,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   a_q, a_d, b_q, b_d;
    logic [3:0]    op_q, op_d;

    logic          is_mul, is_div, is_mt, accept;
    logic          mul_signed;
    logic [63:0]   ext_a, ext_b, prod, mul_res;
    logic          div_signed, a_neg, b_neg;
    logic [31:0]   a_mag, b_mag, q_mag, r_mag, quot, rem;

    assign busy = (state_q != S_IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;

    always_comb begin
        is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
        is_mul = is_mul || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
        is_div = (op == OP_DIV) || (op == OP_DIVU);
        is_mt  = (op == OP_MTHI) || (op == OP_MTLO);
        accept = start && !flush && !busy && (is_mul || is_div || is_mt);
    end

    // Multiply: sign/zero-extend to 64 bits so the low 64 product bits are exact either way.
    always_comb begin
        mul_signed = (op_q == OP_MULT);
`ifdef MDU_MADD_EN
        mul_signed = mul_signed || (op_q == OP_MADD) || (op_q == OP_MSUB);
`endif
        ext_a = mul_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        ext_b = mul_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod  = ext_a * ext_b;
        mul_res = prod;
`ifdef MDU_MADD_EN
        if ((op_q == OP_MADD) || (op_q == OP_MADDU))
            mul_res = {hi_q, lo_q} + prod;
        else if ((op_q == OP_MSUB) || (op_q == OP_MSUBU))
            mul_res = {hi_q, lo_q} - prod;
`endif
    end

    // Divide on magnitudes, then restore signs: quotient truncates toward zero, remainder follows dividend.
    always_comb begin
        div_signed = (op_q == OP_DIV);
        a_neg = div_signed && a_q[31];
        b_neg = div_signed && b_q[31];
        a_mag = a_neg ? (32'd0 - a_q) : a_q;
        b_mag = b_neg ? (32'd0 - b_q) : b_q;
        if (b_mag == 32'd0) b_mag = 32'd1;
        q_mag = a_mag / b_mag;
        r_mag = a_mag % b_mag;
        quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem   = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        if (accept) begin
            if (op == OP_MTHI) begin
                hi_d = a;
            end else if (op == OP_MTLO) begin
                lo_d = a;
            end else begin
                a_d     = a;
                b_d     = b;
                op_d    = op;
                state_d = is_mul ? S_MUL : S_DIV;
                cnt_d   = is_mul ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
            end
        end else if (state_q != S_IDLE) begin
            if (cnt_q == '0) begin
                state_d = S_IDLE;
                if (state_q == S_MUL) begin
                    {hi_d, lo_d} = mul_res;
                end else if (b_q != 32'd0) begin
                    hi_d = rem;
                    lo_d = quot;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
        end
    end
endmodule
